// File: rtl/ccr_pkg.sv
// Shared types and constants for the condition-code register controller.
// Flag layout is {C,N,Z}.
package ccr_pkg;

  localparam int CCR_C = 2;
  localparam int CCR_N = 1;
  localparam int CCR_Z = 0;

  localparam logic [1:0] JSEL_JZ  = 2'b00;
  localparam logic [1:0] JSEL_JN  = 2'b01;
  localparam logic [1:0] JSEL_JC  = 2'b10;
  localparam logic [1:0] JSEL_JMP = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SAVE    = 2'd1,
    ST_RESTORE = 2'd2
  } ccr_state_e;

  function automatic logic jmp_cond(
    input logic [2:0] c,
    input logic [1:0] sel
  );
    logic r;
    case (sel)
      JSEL_JZ: r = c[CCR_Z];
      JSEL_JN: r = c[CCR_N];
      JSEL_JC: r = c[CCR_C];
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ccr_save_stack.sv
// Small LIFO holding CCR snapshots across nested interrupts.
// Full/empty are exported; misuse policy lives in the caller.
module ccr_save_stack #(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [2:0] din_i,
  output logic [2:0] dout_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int PW = $clog2(DEPTH + 1);

  logic [PW-1:0] sp_q;
  logic [2:0]    mem_q [1<<PW];

  assign full_o  = (sp_q == PW'(DEPTH));
  assign empty_o = (sp_q == '0);
  assign dout_o  = mem_q[sp_q - 1'b1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q <= '0;
    end else if (push_i && !full_o) begin
      sp_q <= sp_q + 1'b1;
    end else if (pop_i && !empty_o) begin
      sp_q <= sp_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !full_o) begin
      mem_q[sp_q] <= din_i;
    end
  end

endmodule

// File: rtl/ccr_controller.sv
// Execute-stage CCR owner: flag commit, SETC/CLRC, branch decode, IRQ save/restore.
// Define CCR_JMP_CONSUME_EN to make taken JZ/JN/JC clear their tested flag.
module ccr_controller
  import ccr_pkg::*;
#(
  parameter int INT_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alu_valid,
  input  logic [2:0] alu_ccr,
  input  logic [2:0] flag_mask,
  input  logic       setc,
  input  logic       clrc,
  input  logic       jmp_valid,
  input  logic [1:0] jmp_sel,
  input  logic       int_req,
  input  logic       rti,
  output logic [2:0] ccr,
  output logic       jmp_taken,
  output logic       busy,
  output logic       int_ack,
  output logic       rti_ack,
  output logic       stack_ovf,
  output logic       stack_unf
);

  ccr_state_e state_q;
  logic [2:0] ccr_q;
  logic [2:0] ccr_d;
  logic       int_ack_q;
  logic       rti_ack_q;
  logic       ovf_q;
  logic       unf_q;
  logic       ack_blk;
  logic       stk_push;
  logic       stk_pop;
  logic       stk_full;
  logic       stk_empty;
  logic [2:0] stk_dout;

  assign ccr       = ccr_q;
  assign busy      = (state_q != ST_RUN);
  assign int_ack   = int_ack_q;
  assign rti_ack   = rti_ack_q;
  assign stack_ovf = ovf_q;
  assign stack_unf = unf_q;
  assign jmp_taken = jmp_valid && (state_q == ST_RUN)
                  && jmp_cond(ccr_q, jmp_sel);

  // A request still held in the ack cycle belongs to the acked transfer
  assign ack_blk  = int_ack_q || rti_ack_q;
  assign stk_push = (state_q == ST_SAVE) && !stk_full;
  assign stk_pop  = (state_q == ST_RESTORE) && !stk_empty;

  always_comb begin
    ccr_d = ccr_q;
`ifdef CCR_JMP_CONSUME_EN
    if (jmp_valid && jmp_cond(ccr_q, jmp_sel)) begin
      case (jmp_sel)
        JSEL_JZ: ccr_d[CCR_Z] = 1'b0;
        JSEL_JN: ccr_d[CCR_N] = 1'b0;
        JSEL_JC: ccr_d[CCR_C] = 1'b0;
        default: ;
      endcase
    end
`endif
    if (alu_valid) begin
      ccr_d = (ccr_d & ~flag_mask) | (alu_ccr & flag_mask);
    end
    if (setc && !clrc) begin
      ccr_d[CCR_C] = 1'b1;
    end else if (clrc && !setc) begin
      ccr_d[CCR_C] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      ccr_q     <= '0;
      int_ack_q <= 1'b0;
      rti_ack_q <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      int_ack_q <= 1'b0;
      rti_ack_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          ccr_q <= ccr_d;
          if (!ack_blk && int_req) begin
            state_q <= ST_SAVE;
          end else if (!ack_blk && rti) begin
            state_q <= ST_RESTORE;
          end
        end
        ST_SAVE: begin
          ccr_q     <= '0;
          int_ack_q <= 1'b1;
          if (stk_full) ovf_q <= 1'b1;
          state_q   <= ST_RUN;
        end
        ST_RESTORE: begin
          ccr_q     <= stk_empty ? 3'b000 : stk_dout;
          rti_ack_q <= 1'b1;
          if (stk_empty) unf_q <= 1'b1;
          state_q   <= ST_RUN;
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  ccr_save_stack #(
    .DEPTH (INT_DEPTH)
  ) u_stack (
    .clk     (clk),
    .rst     (rst),
    .push_i  (stk_push),
    .pop_i   (stk_pop),
    .din_i   (ccr_q),
    .dout_o  (stk_dout),
    .full_o  (stk_full),
    .empty_o (stk_empty)
  );

endmodule

// File: tb/tb_ccr_controller.sv
// Bench for ccr_controller: directed scenarios then random traffic,
// all outputs checked every cycle against a queue-based reference model.
module tb_ccr_controller;

  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       alu_valid;
  logic [2:0] alu_ccr;
  logic [2:0] flag_mask;
  logic       setc;
  logic       clrc;
  logic       jmp_valid;
  logic [1:0] jmp_sel;
  logic       int_req;
  logic       rti;
  logic [2:0] ccr;
  logic       jmp_taken;
  logic       busy;
  logic       int_ack;
  logic       rti_ack;
  logic       stack_ovf;
  logic       stack_unf;

  ccr_controller #(.INT_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_ccr   (alu_ccr),
    .flag_mask (flag_mask),
    .setc      (setc),
    .clrc      (clrc),
    .jmp_valid (jmp_valid),
    .jmp_sel   (jmp_sel),
    .int_req   (int_req),
    .rti       (rti),
    .ccr       (ccr),
    .jmp_taken (jmp_taken),
    .busy      (busy),
    .int_ack   (int_ack),
    .rti_ack   (rti_ack),
    .stack_ovf (stack_ovf),
    .stack_unf (stack_unf)
  );

  always #5 clk = ~clk;

  int cmp_n = 0;
  int err_n = 0;

  // Reference model: mode 0 = running, 1 = saving next edge, 2 = restoring next edge
  logic [2:0] m_ccr;
  logic [2:0] m_stk [$];
  int         m_mode;
  logic       m_iack, m_rack, m_ovf, m_unf;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    cmp_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic cond_of(input logic [2:0] c, input logic [1:0] s);
    if (s == 2'd3) return 1'b1;
    return c[s];
  endfunction

  task automatic model_reset();
    m_ccr  = 3'b000;
    m_stk.delete();
    m_mode = 0;
    m_iack = 1'b0;
    m_rack = 1'b0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  task automatic model_update();
    logic [2:0] n;
    logic       blk;
    if (rst) begin
      model_reset();
      return;
    end
    blk    = m_iack | m_rack;
    m_iack = 1'b0;
    m_rack = 1'b0;
    if (m_mode == 1) begin
      if (m_stk.size() < DEPTH) m_stk.push_back(m_ccr);
      else m_ovf = 1'b1;
      m_ccr  = 3'b000;
      m_iack = 1'b1;
      m_mode = 0;
    end else if (m_mode == 2) begin
      if (m_stk.size() > 0) m_ccr = m_stk.pop_back();
      else begin
        m_ccr = 3'b000;
        m_unf = 1'b1;
      end
      m_rack = 1'b1;
      m_mode = 0;
    end else begin
      n = m_ccr;
`ifdef CCR_JMP_CONSUME_EN
      if (jmp_valid && jmp_sel != 2'd3 && cond_of(m_ccr, jmp_sel))
        n[jmp_sel] = 1'b0;
`endif
      if (alu_valid)
        for (int i = 0; i < 3; i++)
          if (flag_mask[i]) n[i] = alu_ccr[i];
      if (setc && !clrc) n[2] = 1'b1;
      if (clrc && !setc) n[2] = 1'b0;
      m_ccr = n;
      if (!blk && int_req) m_mode = 1;
      else if (!blk && rti) m_mode = 2;
    end
  endtask

  task automatic compare_all();
    chk("ccr", 32'(ccr), 32'(m_ccr));
    chk("busy", 32'(busy), 32'(m_mode != 0));
    chk("int_ack", 32'(int_ack), 32'(m_iack));
    chk("rti_ack", 32'(rti_ack), 32'(m_rack));
    chk("stack_ovf", 32'(stack_ovf), 32'(m_ovf));
    chk("stack_unf", 32'(stack_unf), 32'(m_unf));
    chk("jmp_taken", 32'(jmp_taken),
        32'(m_mode == 0 && jmp_valid && cond_of(m_ccr, jmp_sel)));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0;
    alu_ccr   = 3'b000;
    flag_mask = 3'b000;
    setc      = 1'b0;
    clrc      = 1'b0;
    jmp_valid = 1'b0;
    jmp_sel   = 2'b00;
  endtask

  task automatic load_ccr(input logic [2:0] v);
    alu_valid = 1'b1;
    alu_ccr   = v;
    flag_mask = 3'b111;
    cycle();
    idle_inputs();
  endtask

  bit int_pend, rti_pend;

  initial begin
    rst     = 1'b1;
    int_req = 1'b0;
    rti     = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    cycle();
    chk("reset_ccr", 32'(ccr), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    rst = 1'b0;

    // 1: full-mask commit
    alu_valid = 1'b1; alu_ccr = 3'b101; flag_mask = 3'b111;
    cycle();
    chk("t1_ccr", 32'(ccr), 32'b101);

    // 2: partial mask plus SETC
    load_ccr(3'b000);
    alu_valid = 1'b1; alu_ccr = 3'b111; flag_mask = 3'b010; setc = 1'b1;
    cycle();
    idle_inputs();
    chk("t2_ccr", 32'(ccr), 32'b110);

    // 3: single save/restore
    load_ccr(3'b011);
    int_req = 1'b1;
    cycle();
    chk("t3_busy_save", 32'(busy), 32'h1);
    cycle();
    chk("t3_int_ack", 32'(int_ack), 32'h1);
    chk("t3_ccr_clr", 32'(ccr), 32'h0);
    int_req = 1'b0; rti = 1'b1;
    cycle();
    cycle();
    chk("t3_busy_rest", 32'(busy), 32'h1);
    cycle();
    chk("t3_rti_ack", 32'(rti_ack), 32'h1);
    chk("t3_ccr_rest", 32'(ccr), 32'b011);
    rti = 1'b0;
    cycle();

    // 4: nesting past capacity, then unwinding past empty
    load_ccr(3'b100);
    int_req = 1'b1;
    repeat (8) cycle();
    int_req = 1'b0;
    chk("t4_ovf", 32'(stack_ovf), 32'h1);
    cycle();
    rti = 1'b1;
    repeat (5) cycle();
    chk("t4_ccr_mid", 32'(ccr), 32'b100);
    repeat (3) cycle();
    rti = 1'b0;
    chk("t4_ccr_unf", 32'(ccr), 32'h0);
    chk("t4_unf", 32'(stack_unf), 32'h1);
    cycle();

    // 5: JZ on Z=1
    load_ccr(3'b001);
    jmp_valid = 1'b1; jmp_sel = 2'b00;
    #1;
    chk("t5_taken", 32'(jmp_taken), 32'h1);
    cycle();
    jmp_valid = 1'b0;
`ifdef CCR_JMP_CONSUME_EN
    chk("t5_ccr", 32'(ccr), 32'b000);
`else
    chk("t5_ccr", 32'(ccr), 32'b001);
`endif

    // 6: asynchronous reset mid-save
    load_ccr(3'b111);
    int_req = 1'b1;
    cycle();
    chk("t6_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    chk("t6_ccr", 32'(ccr), 32'h0);
    chk("t6_busy0", 32'(busy), 32'h0);
    chk("t6_ovf0", 32'(stack_ovf), 32'h0);
    chk("t6_unf0", 32'(stack_unf), 32'h0);
    chk("t6_ack0", 32'(int_ack | rti_ack), 32'h0);
    model_reset();
    int_req = 1'b0;
    cycle();
    rst = 1'b0;
    rti = 1'b1;
    cycle();
    cycle();
    chk("t6_unf", 32'(stack_unf), 32'h1);
    rti = 1'b0;
    cycle();

    // Random traffic
    int_pend = 1'b0;
    rti_pend = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      alu_valid = ($urandom_range(1) == 1);
      alu_ccr   = 3'($urandom_range(7));
      flag_mask = 3'($urandom_range(7));
      setc      = ($urandom_range(3) == 0);
      clrc      = ($urandom_range(3) == 0);
      jmp_valid = ($urandom_range(1) == 1);
      jmp_sel   = 2'($urandom_range(3));
      if (int_pend && int_ack) begin
        int_pend = 1'b0;
        int_req  = ($urandom_range(3) == 0);
      end else if (!int_pend) begin
        int_pend = ($urandom_range(15) == 0);
        int_req  = int_pend;
      end
      if (rti_pend && rti_ack) begin
        rti_pend = 1'b0;
        rti      = ($urandom_range(3) == 0);
      end else if (!rti_pend) begin
        rti_pend = ($urandom_range(11) == 0);
        rti      = rti_pend;
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
